unpool_merge: RTL



---
 rtl/unpool_merge.sv | 136 +++++++++++++
 1 files changed

// File: rtl/unpool_merge.sv
// Nearest-neighbour 2x2 unpooling of a pooled feature stream, concatenated with the
// time-aligned full-resolution skip stream on the enable/vcnt/hcnt raster interface.
module unpool_merge #(
    parameter int unsigned HEIGHT     = 4,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned W_HEIGHT   = 6,
    parameter int unsigned W_WIDTH    = 10,
    parameter int unsigned UNITS      = 12,
    parameter int unsigned FIXED_BITW = 13,
    localparam int unsigned V_BITW    = $clog2(W_HEIGHT),
    localparam int unsigned H_BITW    = $clog2(W_WIDTH),
    localparam int unsigned FW        = FIXED_BITW * UNITS
) (
    input  logic              clock,
    input  logic              n_rst,
    input  logic              in_enable,
    input  logic [V_BITW-1:0] in_vcnt,
    input  logic [H_BITW-1:0] in_hcnt,
    input  logic [0:FW-1]     in_low,
    input  logic [0:FW-1]     in_skip,
    output logic              out_enable,
    output logic [V_BITW-1:0] out_vcnt,
    output logic [H_BITW-1:0] out_hcnt,
    output logic [0:2*FW-1]   out_y
);

    localparam int unsigned LAT      = W_WIDTH + 2;
    localparam int unsigned SKIP_DLY = W_WIDTH + 1;
    localparam int unsigned NWORDS   = WIDTH / 2;
    localparam int unsigned JW       = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    logic [LAT-2:0]    en_sr_q;
    logic [0:FW-1]     skip_sr_q [SKIP_DLY];
    logic [0:FW-1]     lb_q [NWORDS];
    logic [0:FW-1]     hold_q;

    logic              out_enable_q;
    logic [V_BITW-1:0] out_vcnt_q;
    logic [H_BITW-1:0] out_hcnt_q;
    logic [0:2*FW-1]   out_y_q;

    logic              enable_d;
    logic [V_BITW-1:0] vcnt_d;
    logic [H_BITW-1:0] hcnt_d;
    logic [0:2*FW-1]   y_d;
    logic [0:FW-1]     unpool;
    logic              wr_en;
    logic [JW-1:0]     wr_idx;
    logic [JW-1:0]     rd_idx;

    assign enable_d = en_sr_q[LAT-2];

    // Pooled samples land on odd/odd active coordinates; blanking never disturbs storage.
    assign wr_en  = in_enable && in_vcnt[0] && in_hcnt[0]
                 && (in_hcnt < H_BITW'(WIDTH)) && (in_vcnt < V_BITW'(HEIGHT));
    assign wr_idx = JW'(in_hcnt >> 1);

    // Output position trails the live input position by one row and one column.
    always_comb begin
        vcnt_d = in_vcnt;
        hcnt_d = in_hcnt;
        if (in_hcnt != '0) begin
            hcnt_d = in_hcnt - H_BITW'(1);
            vcnt_d = (in_vcnt == '0) ? V_BITW'(W_HEIGHT - 1) : in_vcnt - V_BITW'(1);
        end else begin
            hcnt_d = H_BITW'(W_WIDTH - 1);
            vcnt_d = (in_vcnt >= V_BITW'(2)) ? in_vcnt - V_BITW'(2)
                                             : in_vcnt + V_BITW'(W_HEIGHT - 2);
        end
    end

    assign rd_idx = JW'(hcnt_d >> 1);

    // Even rows take the live sample then its held copy; odd rows replay the line buffer.
    always_comb begin
        unpool = '0;
        if (!vcnt_d[0]) begin
            unpool = hcnt_d[0] ? hold_q : in_low;
        end else if (hcnt_d < H_BITW'(WIDTH)) begin
            unpool = lb_q[rd_idx];
        end
        y_d = '0;
        if (enable_d) begin
            y_d = {unpool, skip_sr_q[SKIP_DLY-1]};
        end
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            en_sr_q <= '0;
        end else begin
            en_sr_q <= {en_sr_q[LAT-3:0], in_enable};
        end
    end

    always_ff @(posedge clock) begin
        skip_sr_q[0] <= in_skip;
        for (int k = 1; k < SKIP_DLY; k++) begin
            skip_sr_q[k] <= skip_sr_q[k-1];
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            lb_q[wr_idx] <= in_low;
        end
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            hold_q <= '0;
        end else if (wr_en) begin
            hold_q <= in_low;
        end
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            out_enable_q <= 1'b0;
            out_vcnt_q   <= '0;
            out_hcnt_q   <= '0;
            out_y_q      <= '0;
        end else begin
            out_enable_q <= enable_d;
            out_vcnt_q   <= vcnt_d;
            out_hcnt_q   <= hcnt_d;
            out_y_q      <= y_d;
        end
    end

    assign out_enable = out_enable_q;
    assign out_vcnt   = out_vcnt_q;
    assign out_hcnt   = out_hcnt_q;
    assign out_y      = out_y_q;

endmodule
